// File: rtl/ring_phase_checker.sv
// Checks that a one-hot ring phase rotates legally, locks after LOCK_CYCLES good steps,
// counts revolutions and reports violations. Optional macro RING_CHK_STALL_EN makes stalls legal.
module ring_phase_checker #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned LOCK_CYCLES = 4,
  parameter int unsigned CNT_W       = 8,
  localparam int unsigned IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] phase,
  input  logic             sample_en,
  input  logic             err_clr,
  output logic             locked,
  output logic [IDX_W-1:0] phase_idx,
  output logic             rev_pulse,
  output logic [CNT_W-1:0] rev_count,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             err_sticky
);

`ifdef RING_CHK_STALL_EN
  localparam bit StallLegal = 1'b1;
`else
  localparam bit StallLegal = 1'b0;
`endif

  typedef enum logic [1:0] {StSearch, StAcquire, StLocked} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [8:0]       run_q, run_d;
  logic [IDX_W-1:0] phase_idx_d;
  logic             rev_pulse_d, err_d, err_sticky_d;
  logic [CNT_W-1:0] rev_count_d;
  logic [1:0]       err_code_d;

  logic [WIDTH-1:0] expected;
  logic             is_onehot, is_expected, is_stall;
  logic [8:0]       run_inc;

  assign expected    = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
  assign is_onehot   = (phase != '0) && ((phase & (phase - WIDTH'(1))) == '0);
  assign is_expected = (phase == expected);
  assign is_stall    = (phase == prev_q);
  assign run_inc     = run_q + 9'd1;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StSearch;
      prev_q  <= '0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    run_d   = run_q;
    if (sample_en) begin
      unique case (state_q)
        StSearch: begin
          if (is_onehot) begin
            prev_d  = phase;
            run_d   = '0;
            state_d = StAcquire;
          end
        end
        StAcquire: begin
          if (!is_onehot) begin
            run_d   = '0;
            state_d = StSearch;
          end else if (is_expected) begin
            prev_d = phase;
            run_d  = run_inc;
            if (run_inc == 9'(LOCK_CYCLES)) state_d = StLocked;
          end else if (!(StallLegal && is_stall)) begin
            prev_d = phase;
            run_d  = '0;
          end
        end
        StLocked: begin
          if (is_expected) begin
            prev_d = phase;
          end else if (!(StallLegal && is_stall)) begin
            run_d = '0;
            if (is_onehot) begin
              prev_d  = phase;
              state_d = StAcquire;
            end else begin
              state_d = StSearch;
            end
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  // Output next values; all outputs leave through flops
  always_comb begin
    rev_pulse_d = 1'b0;
    err_d       = 1'b0;
    rev_count_d = rev_count;
    err_code_d  = err_code;
    phase_idx_d = '0;
    if (sample_en && state_q == StLocked) begin
      if (is_expected) begin
        if (phase[0]) begin
          rev_pulse_d = 1'b1;
          rev_count_d = rev_count + CNT_W'(1);
        end
      end else if (!(StallLegal && is_stall)) begin
        err_d = 1'b1;
        if (!is_onehot)    err_code_d = 2'b01;
        else if (is_stall) err_code_d = 2'b11;
        else               err_code_d = 2'b10;
      end
    end
    // A new error beats a simultaneous clear
    err_sticky_d = err_d | (err_sticky & ~err_clr);
    if (state_d == StLocked) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (prev_d[i]) phase_idx_d = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_idx  <= '0;
      rev_pulse  <= 1'b0;
      rev_count  <= '0;
      err        <= 1'b0;
      err_code   <= 2'b00;
      err_sticky <= 1'b0;
    end else begin
      phase_idx  <= phase_idx_d;
      rev_pulse  <= rev_pulse_d;
      rev_count  <= rev_count_d;
      err        <= err_d;
      err_code   <= err_code_d;
      err_sticky <= err_sticky_d;
    end
  end

  assign locked = (state_q == StLocked);

endmodule

// File: tb/tb_ring_phase_checker.sv
// Directed table-driven bench for ring_phase_checker (WIDTH=4, LOCK_CYCLES=4, CNT_W=8).
module tb_ring_phase_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] phase;
  logic       sample_en;
  logic       err_clr;
  logic       locked;
  logic [1:0] phase_idx;
  logic       rev_pulse;
  logic [7:0] rev_count;
  logic       err;
  logic [1:0] err_code;
  logic       err_sticky;

  int checks = 0;
  int errors = 0;

  ring_phase_checker #(
    .WIDTH      (4),
    .LOCK_CYCLES(4),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .phase     (phase),
    .sample_en (sample_en),
    .err_clr   (err_clr),
    .locked    (locked),
    .phase_idx (phase_idx),
    .rev_pulse (rev_pulse),
    .rev_count (rev_count),
    .err       (err),
    .err_code  (err_code),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       clr;
    logic [3:0] ph;
    logic       lk;
    logic [1:0] idx;
    logic       rp;
    logic [7:0] rc;
    logic       er;
    logic [1:0] code;
    logic       st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic clr, input logic [3:0] ph, input logic lk,
                     input logic [1:0] idx, input logic rp, input logic [7:0] rc, input logic er,
                     input logic [1:0] code, input logic st);
    vec_t v;
    v.en = en; v.clr = clr; v.ph = ph; v.lk = lk; v.idx = idx;
    v.rp = rp; v.rc = rc; v.er = er; v.code = code; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic lk, input logic [1:0] idx,
                           input logic rp, input logic [7:0] rc, input logic er,
                           input logic [1:0] code, input logic st);
    check({tag, ".locked"}, 32'(locked), 32'(lk));
    check({tag, ".phase_idx"}, 32'(phase_idx), 32'(idx));
    check({tag, ".rev_pulse"}, 32'(rev_pulse), 32'(rp));
    check({tag, ".rev_count"}, 32'(rev_count), 32'(rc));
    check({tag, ".err"}, 32'(err), 32'(er));
    check({tag, ".err_code"}, 32'(err_code), 32'(code));
    check({tag, ".err_sticky"}, 32'(err_sticky), 32'(st));
  endtask

  task automatic step(input logic en, input logic clr, input logic [3:0] ph);
    @(negedge clk);
    sample_en = en;
    err_clr   = clr;
    phase     = ph;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; sample_en = 1'b0; err_clr = 1'b0; phase = 4'b0000;

    //  en clr phase   lk idx rp rc er code st
    add(1, 0, 4'b0001, 0, 0, 0, 0, 0, 2'b00, 0);  // SEARCH -> ACQUIRE
    add(1, 0, 4'b0010, 0, 0, 0, 0, 0, 2'b00, 0);
    add(1, 0, 4'b0100, 0, 0, 0, 0, 0, 2'b00, 0);
    add(1, 0, 4'b1000, 0, 0, 0, 0, 0, 2'b00, 0);
    add(1, 0, 4'b0001, 1, 0, 0, 0, 0, 2'b00, 0);  // lock, no rev from ACQUIRE
    add(0, 0, 4'b1111, 1, 0, 0, 0, 0, 2'b00, 0);  // sample_en=0 freezes
    add(1, 0, 4'b0010, 1, 1, 0, 0, 0, 2'b00, 0);
    add(1, 0, 4'b0100, 1, 2, 0, 0, 0, 2'b00, 0);
    add(1, 0, 4'b1000, 1, 3, 0, 0, 0, 2'b00, 0);
    add(1, 0, 4'b0001, 1, 0, 1, 1, 0, 2'b00, 0);  // revolution
    add(1, 0, 4'b0010, 1, 1, 0, 1, 0, 2'b00, 0);
    add(1, 0, 4'b1000, 0, 0, 0, 1, 1, 2'b10, 1);  // wrong position
    add(1, 0, 4'b0001, 0, 0, 0, 1, 0, 2'b10, 1);
    add(1, 0, 4'b0010, 0, 0, 0, 1, 0, 2'b10, 1);
    add(1, 0, 4'b0100, 0, 0, 0, 1, 0, 2'b10, 1);
    add(1, 0, 4'b1000, 1, 3, 0, 1, 0, 2'b10, 1);  // relock
    add(1, 0, 4'b0001, 1, 0, 1, 2, 0, 2'b10, 1);
    add(1, 0, 4'b0011, 0, 0, 0, 2, 1, 2'b01, 1);  // not one-hot -> SEARCH
    add(1, 0, 4'b0000, 0, 0, 0, 2, 0, 2'b01, 1);
    add(1, 1, 4'b0000, 0, 0, 0, 2, 0, 2'b01, 0);  // clear sticky
    add(1, 0, 4'b0001, 0, 0, 0, 2, 0, 2'b01, 0);
    add(1, 0, 4'b0010, 0, 0, 0, 2, 0, 2'b01, 0);
    add(1, 0, 4'b0100, 0, 0, 0, 2, 0, 2'b01, 0);
    add(1, 0, 4'b1000, 0, 0, 0, 2, 0, 2'b01, 0);
    add(1, 0, 4'b0001, 1, 0, 0, 2, 0, 2'b01, 0);
    add(1, 0, 4'b0010, 1, 1, 0, 2, 0, 2'b01, 0);
    add(1, 0, 4'b0100, 1, 2, 0, 2, 0, 2'b01, 0);  // locked at 0100

    repeat (2) @(posedge clk);
    #1 check_all("reset", 0, 0, 0, 0, 0, 2'b00, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].clr, vecs[i].ph);
      check_all($sformatf("vec%0d", i), vecs[i].lk, vecs[i].idx, vecs[i].rp, vecs[i].rc,
                vecs[i].er, vecs[i].code, vecs[i].st);
    end

    // Stall while locked at 0100, with err_clr on the same cycle
    step(1, 1, 4'b0100);
`ifdef RING_CHK_STALL_EN
    check_all("stall", 1, 2, 0, 2, 0, 2'b01, 0);
    step(1, 1, 4'b1000);
    check_all("stall_next", 1, 3, 0, 2, 0, 2'b01, 0);
    step(1, 0, 4'b0001);
    check_all("stall_rev", 1, 0, 1, 3, 0, 2'b01, 0);
`else
    check_all("stall", 0, 0, 0, 2, 1, 2'b11, 1);
    step(1, 1, 4'b1000);
    check_all("clr_alone", 0, 0, 0, 2, 0, 2'b11, 0);
    step(1, 0, 4'b0001);
    step(1, 0, 4'b0010);
    step(1, 0, 4'b0100);
    check_all("relock2", 1, 2, 0, 2, 0, 2'b11, 0);
`endif

    // Async reset between edges
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_all("async_rst", 0, 0, 0, 0, 0, 2'b00, 0);
    @(negedge clk);
    reset = 1'b1;

    // First sample after reset is treated as SEARCH
    step(1, 0, 4'b0010);
    check_all("post_rst0", 0, 0, 0, 0, 0, 2'b00, 0);
    step(1, 0, 4'b0100);
    step(1, 0, 4'b1000);
    step(1, 0, 4'b0001);
    check_all("post_rst3", 0, 0, 0, 0, 0, 2'b00, 0);
    step(1, 0, 4'b0010);
    check_all("post_rst_lock", 1, 1, 0, 0, 0, 2'b00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_phase_checker.md
Name: ring_phase_checker

Overview:
Downstream consumer of the 4-bit ring counter. It samples the one-hot phase vector each clock and checks that the hot bit rotates legally: bit0 -> bit1 -> ... -> bit(WIDTH-1) -> bit0. It locks after a run of correct rotations, counts full revolutions, and flags illegal or out-of-sequence phases. It also provides the encoded phase index to scan and mux logic that follows.

Parameters:
WIDTH, 4, ring length; width of phase input.
LOCK_CYCLES, 4, consecutive correct rotations needed to enter LOCKED (1..255).
CNT_W, 8, width of revolution counter.

Ports:
clk  input  1  system clock, all state on posedge.
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
phase  input  WIDTH  ring counter q vector.
sample_en  input  1  phase is checked only on cycles where this is 1.
err_clr  input  1  clears err_sticky.
locked  output  1  1 while in LOCKED state.
phase_idx  output  $clog2(WIDTH)  binary index of last accepted phase while locked; 0 otherwise.
rev_pulse  output  1  one-cycle pulse when a locked ring wraps to bit0.
rev_count  output  CNT_W  number of revolutions; wraps modulo 2^CNT_W.
err  output  1  one-cycle pulse when a violation is seen in LOCKED.
err_code  output  2  cause of last error: 01 not one-hot, 10 wrong position, 11 stall; holds until next error.
err_sticky  output  1  set on any err, held until err_clr.

Behaviour:
- Reset (reset=0, async): state=SEARCH; prev=0, run=0. All outputs are 0, including rev_count and err_code.
- All outputs are registered. They reflect a sample one cycle after the sampling edge.
- expected = rotate-left-by-1(prev), i.e. bit WIDTH-1 wraps to bit0.
- Cycles with sample_en=0 change nothing: state, prev, run and counters hold. Pulses are 0.
- SEARCH:
  - one-hot phase -> prev<=phase, run<=0, go ACQUIRE.
  - otherwise stay in SEARCH.
- ACQUIRE:
  - phase==expected -> prev<=phase, run<=run+1. When run+1==LOCK_CYCLES, go LOCKED.
  - other one-hot phase -> prev<=phase, run<=0, stay in ACQUIRE.
  - not one-hot -> go SEARCH.
  - ACQUIRE never raises err and never counts revolutions.
- LOCKED:
  - phase==expected -> prev<=phase. If phase[0]==1, rev_pulse=1 and rev_count increments.
  - any mismatch -> err=1, err_sticky=1, err_code set, run<=0.
    - If phase is one-hot, prev<=phase and go ACQUIRE.
    - Otherwise go SEARCH.
  - Mismatch classification:
    - zero or multi-hot -> 01.
    - phase==prev -> 11.
    - any other one-hot value -> 10.
- locked=1 exactly while state==LOCKED. phase_idx = index of prev's hot bit when locked, else 0.
- err_clr and a new error on the same cycle: set wins, so err_sticky stays 1.
- rev_count is cleared only by reset. It persists across loss of lock.
- Reset asserted mid-operation aborts immediately. After release, the first sample is treated as in SEARCH.

Optional Feature:
Macro RING_CHK_STALL_EN.
- Defined: in LOCKED, phase==prev is legal. There is no err, prev is unchanged, no revolution is counted, and the block stays LOCKED. In ACQUIRE, a stall holds run.
- Undefined: a stall is an error in LOCKED (code 11). In ACQUIRE it is treated as "other one-hot" and resets run to 0.

Test Plan:
1. Lock: WIDTH=4, LOCK_CYCLES=4, sample_en=1, phases 0001,0010,0100,1000,0001 -> locked=1 after the 5th sample edge, phase_idx=0, rev_pulse=0, err=0.
2. Revolution: from locked, phases 0010,0100,1000,0001 -> phase_idx 1,2,3,0; one rev_pulse after 0001; rev_count=1.
3. Wrong position: locked at 0010, inject 1000 -> err pulse, err_code=10, err_sticky=1, locked=0, state ACQUIRE. Then 0001,0010,0100,1000 -> relock.
4. Illegal: locked, inject 0011 -> err_code=01, SEARCH, locked=0; 0000 keeps SEARCH; rev_count unchanged.
5. Stall/clear: locked at 0100, repeat 0100 -> without macro err_code=11, err=1. Repeat with err_clr=1 on the same error cycle -> err_sticky=1; err_clr alone next cycle -> 0. With RING_CHK_STALL_EN -> no err, locked stays 1.
6. Async reset: drive reset=0 mid-LOCKED between clock edges -> locked, rev_count, err_sticky and phase_idx are 0 before the next edge. sample_en=0 cycles freeze all state.
